// File: rtl/alu_seq_if.sv
// alu_seq request/result bundle.
// Master drives the request, slave returns result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] inputA;
  logic [WIDTH-1:0] inputB;
  logic             carry_in;
  logic             decimal_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALU_output;
  logic [7:0]       ALU_flags_output;
  logic [7:0]       ALU_flags_mask;

  modport master (
    output start, alu_op, inputA, inputB,
    output carry_in, decimal_in,
    input  busy, done, ALU_output,
    input  ALU_flags_output, ALU_flags_mask
  );

  modport slave (
    input  start, alu_op, inputA, inputB,
    input  carry_in, decimal_in,
    output busy, done, ALU_output,
    output ALU_flags_output, ALU_flags_mask
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle 6502-style ALU with C/Z/V/N flags.
// Optional BCD adjust cycle for 8-bit ADC/SBC.
module alu_seq #(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam bit DEC_OK = DECIMAL_EN && (WIDTH == 8);

  localparam logic [3:0] OP_ASL = 4'd0;
  localparam logic [3:0] OP_LSR = 4'd1;
  localparam logic [3:0] OP_ROL = 4'd2;
  localparam logic [3:0] OP_ROR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_ORA = 4'd5;
  localparam logic [3:0] OP_EOR = 4'd6;
  localparam logic [3:0] OP_ADC = 4'd7;
  localparam logic [3:0] OP_SBC = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;

  typedef enum logic [1:0] {
    IDLE, EXEC, ADJ, DONE
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             d_q;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic             cf;
  logic             vf;
  logic [7:0]       msk;
  logic [7:0]       bin_f;
  logic [4:0]       lo;
  logic [7:0]       t;
  logic             dc;
  logic [7:0]       dec_f;
  logic             is_dec;

  // Shared adder: ADC uses B, SBC/CMP use ~B; CMP forces carry-in.
  always_comb begin
    b_eff = (op_q == OP_ADC) ? b_q : ~b_q;
    cin   = (op_q == OP_CMP) ? 1'b1 : c_q;
    sum   = {1'b0, a_q} + {1'b0, b_eff}
          + {{WIDTH{1'b0}}, cin};
    r   = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    msk = 8'h00;
    case (op_q)
      OP_ASL: begin
        r   = {a_q[WIDTH-2:0], 1'b0};
        cf  = a_q[WIDTH-1];
        msk = 8'h83;
      end
      OP_LSR: begin
        r   = {1'b0, a_q[WIDTH-1:1]};
        cf  = a_q[0];
        msk = 8'h83;
      end
      OP_ROL: begin
        r   = {a_q[WIDTH-2:0], c_q};
        cf  = a_q[WIDTH-1];
        msk = 8'h83;
      end
      OP_ROR: begin
        r   = {c_q, a_q[WIDTH-1:1]};
        cf  = a_q[0];
        msk = 8'h83;
      end
      OP_AND: begin
        r   = a_q & b_q;
        msk = 8'h82;
      end
      OP_ORA: begin
        r   = a_q | b_q;
        msk = 8'h82;
      end
      OP_EOR: begin
        r   = a_q ^ b_q;
        msk = 8'h82;
      end
      OP_ADC, OP_SBC: begin
        r   = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        vf  = (a_q[WIDTH-1] == b_eff[WIDTH-1])
           && (r[WIDTH-1] != a_q[WIDTH-1]);
        msk = 8'hC3;
      end
      OP_CMP: begin
        r   = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        msk = 8'h83;
      end
      OP_INC: begin
        r   = a_q + WIDTH'(1);
        msk = 8'h82;
      end
      OP_DEC: begin
        r   = a_q - WIDTH'(1);
        msk = 8'h82;
      end
      default: ;
    endcase
    bin_f = {r[WIDTH-1], vf, 4'b0000, ~|r, cf} & msk;
  end

  // BCD correction works from the binary sum and nibble carry.
  always_comb begin
    lo = {1'b0, a_q[3:0]} + {1'b0, b_eff[3:0]}
       + {4'b0000, c_q};
    t  = 8'(sum[WIDTH-1:0]);
    dc = sum[WIDTH];
    if (op_q == OP_ADC) begin
      if (lo > 5'd9) t = t + 8'h06;
      dc = (t[7:4] > 4'd9) || sum[WIDTH];
      if (dc) t = t + 8'h60;
    end else begin
      if (!lo[4]) t = t - 8'h06;
      if (!sum[WIDTH]) t = t - 8'h60;
    end
    dec_f = {t[7], bin_f[6], 4'b0000, ~|t, dc};
  end

  assign is_dec = DEC_OK && d_q
               && (op_q == OP_ADC || op_q == OP_SBC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      op_q                 <= '0;
      a_q                  <= '0;
      b_q                  <= '0;
      c_q                  <= 1'b0;
      d_q                  <= 1'b0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.ALU_output       <= '0;
      bus.ALU_flags_output <= '0;
      bus.ALU_flags_mask   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.alu_op;
            a_q      <= bus.inputA;
            b_q      <= bus.inputB;
            c_q      <= bus.carry_in;
            d_q      <= bus.decimal_in;
            bus.busy <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          bus.ALU_output       <= r;
          bus.ALU_flags_output <= bin_f;
          bus.ALU_flags_mask   <= msk;
          if (is_dec) begin
            state <= ADJ;
          end else begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        ADJ: begin
          bus.ALU_output       <= WIDTH'(t);
          bus.ALU_flags_output <= dec_f;
          bus.busy             <= 1'b0;
          bus.done             <= 1'b1;
          state                <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (8-bit decimal and 16-bit).
// Random ops are compared against an integer reference model.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8), .DECIMAL_EN(1'b1)) u8 (
    .clk(clk), .rst(rst), .bus(if8)
  );
  alu_seq #(.WIDTH(16), .DECIMAL_EN(1'b1)) u16 (
    .clk(clk), .rst(rst), .bus(if16)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic longint sgn(input longint v, input longint mod);
    return (v >= mod / 2) ? v - mod : v;
  endfunction

  // Integer model of the 6502 rules, decimal only for 8-bit.
  function automatic void ref_op(
    input int w, input int op, input longint a, input longint b,
    input bit c, input bit d, output longint r,
    output logic [7:0] f, output logic [7:0] m, output int lat);
    longint mod, msb, s, sb, ss, lo, t;
    bit cf, vf;
    mod = longint'(1) << w;
    msb = mod / 2;
    cf = 0; vf = 0; r = 0; m = 8'h00; lat = 2;
    case (op)
      0: begin r = (a * 2) % mod; cf = a >= msb; m = 8'h83; end
      1: begin r = a / 2; cf = (a % 2) == 1; m = 8'h83; end
      2: begin r = (a * 2 + longint'(c)) % mod; cf = a >= msb; m = 8'h83; end
      3: begin r = a / 2 + (c ? msb : 0); cf = (a % 2) == 1; m = 8'h83; end
      4: begin r = a & b; m = 8'h82; end
      5: begin r = a | b; m = 8'h82; end
      6: begin r = a ^ b; m = 8'h82; end
      7, 8: begin
        sb = (op == 7) ? b : mod - 1 - b;
        s  = a + sb + longint'(c);
        r  = s % mod;
        cf = s >= mod;
        ss = sgn(a, mod) + sgn(sb, mod) + longint'(c);
        vf = (ss >= msb) || (ss < -msb);
        m  = 8'hC3;
        if (w == 8 && d) begin
          lat = 3;
          t = s % 256;
          if (op == 7) begin
            lo = (a % 16) + (b % 16) + longint'(c);
            if (lo > 9) t = (t + 6) % 256;
            cf = (t / 16 > 9) || (s >= 256);
            if (cf) t = (t + 96) % 256;
          end else begin
            lo = (a % 16) + (15 - b % 16) + longint'(c);
            if (lo < 16) t = (t + 250) % 256;
            if (s < 256) t = (t + 160) % 256;
            cf = s >= 256;
          end
          r = t;
        end
      end
      9: begin r = (a - b + mod) % mod; cf = a >= b; m = 8'h83; end
      10: begin r = (a + 1) % mod; m = 8'h82; end
      11: begin r = (a - 1 + mod) % mod; m = 8'h82; end
      default: ;
    endcase
    f = {r >= msb, vf, 4'b0000, r == 0, cf} & m;
  endfunction

  // Drives one request and observes the result; no checking here.
  task automatic issue(
    input bit wide, input logic [3:0] op, input logic [15:0] a,
    input logic [15:0] b, input bit c, input bit d,
    output int lat, output logic [15:0] r, output logic [7:0] f,
    output logic [7:0] m, output bit busy1, output bit held);
    bit dn;
    lat = -1; r = '0; f = '0; m = '0; busy1 = 0; held = 0;
    if (wide) begin
      if16.start = 1; if16.alu_op = op; if16.inputA = a;
      if16.inputB = b; if16.carry_in = c; if16.decimal_in = d;
    end else begin
      if8.start = 1; if8.alu_op = op; if8.inputA = a[7:0];
      if8.inputB = b[7:0]; if8.carry_in = c; if8.decimal_in = d;
    end
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        if (wide) begin
          if16.start = 0; if16.alu_op = 4'($urandom);
          if16.inputA = 16'($urandom); if16.inputB = 16'($urandom);
          if16.carry_in = 1'($urandom); if16.decimal_in = 1'($urandom);
          busy1 = if16.busy;
        end else begin
          if8.start = 0; if8.alu_op = 4'($urandom);
          if8.inputA = 8'($urandom); if8.inputB = 8'($urandom);
          if8.carry_in = 1'($urandom); if8.decimal_in = 1'($urandom);
          busy1 = if8.busy;
        end
      end
      dn = wide ? if16.done : if8.done;
      if (dn) begin
        lat = n;
        r = wide ? if16.ALU_output : {8'h00, if8.ALU_output};
        f = wide ? if16.ALU_flags_output : if8.ALU_flags_output;
        m = wide ? if16.ALU_flags_mask : if8.ALU_flags_mask;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      if (wide)
        held = !if16.done && if16.ALU_output === r
            && if16.ALU_flags_output === f && if16.ALU_flags_mask === m;
      else
        held = !if8.done && if8.ALU_output === r[7:0]
            && if8.ALU_flags_output === f && if8.ALU_flags_mask === m;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({if8.busy, if8.done, if8.ALU_output, if8.ALU_flags_output,
         if8.ALU_flags_mask} !== 26'h0)
      $display("FAIL reset8: busy=%b done=%b out=%h f=%h m=%h want all 0",
               if8.busy, if8.done, if8.ALU_output, if8.ALU_flags_output,
               if8.ALU_flags_mask);
    else n_pass++;
    n_total++;
    if ({if16.busy, if16.done, if16.ALU_output, if16.ALU_flags_output,
         if16.ALU_flags_mask} !== 34'h0)
      $display("FAIL reset16: out=%h f=%h m=%h want all 0",
               if16.ALU_output, if16.ALU_flags_output, if16.ALU_flags_mask);
    else n_pass++;
    rst = 0;
  endtask

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a, b;
    logic       c, d;
    logic [7:0] er, ef, em;
    logic [1:0] lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    int lat; logic [15:0] r; logic [7:0] f, m; bit b1, hd;
    v[0] = '{4'd0, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03, 8'h83, 2'd2};
    v[1] = '{4'd7, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 8'hC0, 8'hC3, 2'd2};
    v[2] = '{4'd7, 8'h58, 8'h46, 1'b0, 1'b1, 8'h04, 8'h41, 8'hC3, 2'd3};
    v[3] = '{4'd8, 8'h46, 8'h12, 1'b1, 1'b1, 8'h34, 8'h01, 8'hC3, 2'd3};
    v[4] = '{4'd9, 8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 8'h80, 8'h83, 2'd2};
    v[5] = '{4'd1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03, 8'h83, 2'd2};
    for (int i = 0; i < 6; i++) begin
      issue(0, v[i].op, {8'h00, v[i].a}, {8'h00, v[i].b}, v[i].c, v[i].d,
            lat, r, f, m, b1, hd);
      n_total++;
      if (lat !== int'(v[i].lat))
        $display("FAIL dir%0d latency: got %0d want %0d", i, lat, v[i].lat);
      else n_pass++;
      n_total++;
      if ({r[7:0], f, m} !== {v[i].er, v[i].ef, v[i].em})
        $display("FAIL dir%0d result: got r=%h f=%h m=%h want r=%h f=%h m=%h",
                 i, r[7:0], f, m, v[i].er, v[i].ef, v[i].em);
      else n_pass++;
      n_total++;
      if (!hd) $display("FAIL dir%0d hold: got done/outputs changed want held", i);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen = 0;
    if8.start = 1; if8.alu_op = 4'd7; if8.inputA = 8'h50;
    if8.inputB = 8'h50; if8.carry_in = 0; if8.decimal_in = 0;
    @(posedge clk); #1;
    if8.start = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n_total++;
    if ({if8.busy, if8.done, if8.ALU_output, if8.ALU_flags_output,
         if8.ALU_flags_mask} !== 26'h0)
      $display("FAIL mid_reset: busy=%b done=%b out=%h f=%h m=%h want all 0",
               if8.busy, if8.done, if8.ALU_output, if8.ALU_flags_output,
               if8.ALU_flags_mask);
    else n_pass++;
    repeat (4) begin
      @(posedge clk); #1;
      if (if8.done) seen = 1;
    end
    n_total++;
    if (seen) $display("FAIL mid_reset_done: got done pulse want none");
    else n_pass++;
  endtask

  task automatic test_start_with_reset();
    bit seen = 0;
    rst = 1; if8.start = 1; if8.alu_op = 4'd10; if8.inputA = 8'h33;
    @(posedge clk); #1;
    rst = 0; if8.start = 0;
    n_total++;
    if (if8.busy !== 1'b0)
      $display("FAIL start_rst_busy: got %b want 0", if8.busy);
    else n_pass++;
    repeat (4) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) seen = 1;
    end
    n_total++;
    if (seen) $display("FAIL start_rst_drop: got activity want none");
    else n_pass++;
  endtask

  task automatic test_random(input bit wide, input int cnt);
    int w, lat, elat, op;
    logic [15:0] a, b, r;
    logic [7:0] f, m, ef, em;
    longint er;
    bit c, d, b1, hd;
    w = wide ? 16 : 8;
    for (int i = 0; i < cnt; i++) begin
      op = int'($urandom_range(0, 15));
      c = 1'($urandom); d = 1'($urandom);
      if (!wide && $urandom_range(0, 1) == 1) begin
        a = {8'h00, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        b = {8'h00, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        a = wide ? 16'($urandom) : {8'h00, 8'($urandom)};
        b = wide ? 16'($urandom) : {8'h00, 8'($urandom)};
      end
      ref_op(w, op, longint'(a), longint'(b), c, d, er, ef, em, elat);
      issue(wide, 4'(op), a, b, c, d, lat, r, f, m, b1, hd);
      n_total++;
      if (lat !== elat)
        $display("FAIL rnd%0d_%0d latency op=%0d: got %0d want %0d",
                 w, i, op, lat, elat);
      else n_pass++;
      n_total++;
      if (r !== 16'(er))
        $display("FAIL rnd%0d_%0d result op=%0d a=%h b=%h c=%b d=%b: got %h want %h",
                 w, i, op, a, b, c, d, r, 16'(er));
      else n_pass++;
      n_total++;
      if ({f, m} !== {ef, em})
        $display("FAIL rnd%0d_%0d flags op=%0d a=%h b=%h: got f=%h m=%h want f=%h m=%h",
                 w, i, op, a, b, f, m, ef, em);
      else n_pass++;
      n_total++;
      if (!b1 || !hd)
        $display("FAIL rnd%0d_%0d handshake: got busy1=%b held=%b want 1 1",
                 w, i, b1, hd);
      else n_pass++;
    end
  endtask

  task automatic test_wide();
    int lat; logic [15:0] r; logic [7:0] f, m; bit b1, hd;
    issue(1, 4'd10, 16'hFFFF, 16'h0, 0, 0, lat, r, f, m, b1, hd);
    n_total++;
    if ({r, f, m} !== {16'h0000, 8'h02, 8'h82} || lat !== 2)
      $display("FAIL inc16: got r=%h f=%h m=%h lat=%0d want 0000 02 82 2",
               r, f, m, lat);
    else n_pass++;
    issue(1, 4'd7, 16'h0058, 16'h0046, 0, 1, lat, r, f, m, b1, hd);
    n_total++;
    if (lat !== 2 || r !== 16'h009E || f !== 8'h00)
      $display("FAIL dec16_adc: got r=%h f=%h lat=%0d want 009e 00 2",
               r, f, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_hist[32];
    int last = -1, pulses = 0;
    bit prev = 0;
    if16.start = 1; if16.alu_op = 4'd10;
    for (int e = 0; e < 30; e++) begin
      a_hist[e] = 16'($urandom);
      if16.inputA = a_hist[e];
      @(posedge clk); #1;
      if (if16.done) begin
        pulses++;
        n_total++;
        if (prev || (last >= 0 && e - last != 3))
          $display("FAIL b2b_spacing: got done at edge %0d after %0d want gap 3",
                   e, last);
        else n_pass++;
        if (e > 0) begin
          n_total++;
          if (if16.ALU_output !== a_hist[e-1] + 16'd1)
            $display("FAIL b2b_result edge %0d: got %h want %h",
                     e, if16.ALU_output, a_hist[e-1] + 16'd1);
          else n_pass++;
        end
        last = e;
      end
      prev = if16.done;
    end
    if16.start = 0;
    n_total++;
    if (pulses != 10)
      $display("FAIL b2b_count: got %0d done pulses want 10", pulses);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    if8.start = 0; if8.alu_op = 0; if8.inputA = 0; if8.inputB = 0;
    if8.carry_in = 0; if8.decimal_in = 0;
    if16.start = 0; if16.alu_op = 0; if16.inputA = 0; if16.inputB = 0;
    if16.carry_in = 0; if16.decimal_in = 0;
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_start_with_reset();
    test_random(0, 60);
    test_wide();
    test_back_to_back();
    test_random(1, 40);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
